// File: rtl/segre_store_buffer_n_pkg.sv
// Shared types and helpers for the N-entry store buffer.
//   - Width constants for addresses, data words and instruction ids.
//   - memop_data_type_e: access size of a load or store.
//   - sb_entry_t: one buffered word with its byte mask and owning id.
//   - sb_byte_mask / sb_misaligned: derive the lane mask and the alignment fault for an access.
package segre_store_buffer_n_pkg;

    localparam int unsigned SB_NUM_ELEMS = 4;
    localparam int unsigned ADDR_SIZE    = 32;
    localparam int unsigned WORD_SIZE    = 32;
    localparam int unsigned HF_PTR       = 3;
    localparam int unsigned SB_LANES     = WORD_SIZE / 8;
    localparam int unsigned WADDR_W      = ADDR_SIZE - 2;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef struct packed {
        logic                 valid;
        logic [WADDR_W-1:0]   waddr;
        logic [WORD_SIZE-1:0] data;
        logic [SB_LANES-1:0]  mask;
        logic [HF_PTR-1:0]    id;
    } sb_entry_t;

    function automatic logic [SB_LANES-1:0] sb_byte_mask(memop_data_type_e t, logic [1:0] off);
        logic [SB_LANES-1:0] m;
        unique case (t)
            BYTE:    m = 4'b0001 << off;
            HALF:    m = 4'b0011 << off;
            WORD:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // The unused encoding is reported as misaligned so it is never performed.
    function automatic logic sb_misaligned(memop_data_type_e t, logic [1:0] off);
        logic bad;
        unique case (t)
            BYTE:    bad = 1'b0;
            HALF:    bad = off[0];
            WORD:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/segre_store_buffer_n_if.sv
// Store buffer bus: request/lookup side from TL and drain side towards the dcache.
//   master: TL + dcache (drives requests and flush_chance_i, observes results)
//   slave : the store buffer
interface segre_store_buffer_n_if;
    import segre_store_buffer_n_pkg::*;

    logic                   req_store_i;
    logic                   req_load_i;
    logic [ADDR_SIZE-1:0]   addr_i;
    logic [WORD_SIZE-1:0]   data_i;
    memop_data_type_e       memop_type_i;
    logic [HF_PTR-1:0]      instr_id_i;
    logic                   hit_o;
    logic                   miss_o;
    logic                   trouble_o;
    logic                   buffer_merge_o;
    logic [WORD_SIZE-1:0]   data_load_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   flush_chance_i;
    logic                   flush_valid_o;
    logic [ADDR_SIZE-1:0]   addr_o;
    logic [WORD_SIZE-1:0]   data_flush_o;
    logic [SB_LANES-1:0]    byte_en_o;
    logic [HF_PTR-1:0]      flush_id_o;

    modport master (
        output req_store_i, req_load_i, addr_i, data_i, memop_type_i, instr_id_i, flush_chance_i,
        input  hit_o, miss_o, trouble_o, buffer_merge_o, data_load_o, full_o, empty_o,
        input  flush_valid_o, addr_o, data_flush_o, byte_en_o, flush_id_o
    );

    modport slave (
        input  req_store_i, req_load_i, addr_i, data_i, memop_type_i, instr_id_i, flush_chance_i,
        output hit_o, miss_o, trouble_o, buffer_merge_o, data_load_o, full_o, empty_o,
        output flush_valid_o, addr_o, data_flush_o, byte_en_o, flush_id_o
    );

endinterface

// File: rtl/segre_store_buffer_n_lookup.sv
// Combinational word-address match against every buffered entry.
//   entries_i     : all entries (index = FIFO slot)
//   waddr_i       : word address to look up
//   match_o       : one-hot vector of valid entries holding waddr_i
//   match_idx_o   : slot of the match (0 when none)
//   match_entry_o : matched entry; valid=0 when nothing matched
module segre_store_buffer_n_lookup
    import segre_store_buffer_n_pkg::*;
#(
    parameter int unsigned NUM_ELEMS = SB_NUM_ELEMS,
    localparam int unsigned PtrW     = $clog2(NUM_ELEMS)
) (
    input  sb_entry_t [NUM_ELEMS-1:0] entries_i,
    input  logic [WADDR_W-1:0]        waddr_i,
    output logic [NUM_ELEMS-1:0]      match_o,
    output logic [PtrW-1:0]           match_idx_o,
    output sb_entry_t                 match_entry_o
);

    always_comb begin
        match_o       = '0;
        match_idx_o   = '0;
        match_entry_o = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            if (entries_i[i].valid && (entries_i[i].waddr == waddr_i)) begin
                match_o[i]    = 1'b1;
                match_idx_o   = PtrW'(i);
                match_entry_o = entries_i[i];
            end
        end
    end

endmodule

// File: rtl/segre_store_buffer_n.sv
// N-entry store buffer between TL and the dcache.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   sb (slave)   : store/load requests, same-cycle load forwarding and status flags,
//                  plus the head-of-FIFO drain port towards the dcache.
// Stores merge per byte into an existing entry for the same word, otherwise allocate at the
// tail. Loads are answered combinationally from the state before the clock edge.
module segre_store_buffer_n
    import segre_store_buffer_n_pkg::*;
#(
    parameter int unsigned NUM_ELEMS = SB_NUM_ELEMS
) (
    input logic                   clk_i,
    input logic                   rst_i,
    segre_store_buffer_n_if.slave sb
);

    localparam int unsigned PtrW = $clog2(NUM_ELEMS);

    sb_entry_t [NUM_ELEMS-1:0] entries_q, entries_d;
    logic [PtrW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [PtrW:0]             count_q, count_d;

    logic [NUM_ELEMS-1:0]      match_vec;
    logic [PtrW-1:0]           match_idx;
    sb_entry_t                 match_entry;

    logic [1:0]                off;
    logic [SB_LANES-1:0]       acc_mask, size_mask;
    logic                      misaligned, full, empty, pop, head_hit;
    logic                      do_merge, do_alloc;
    logic [WORD_SIZE-1:0]      store_data, size_bits;

    assign off        = sb.addr_i[1:0];
    assign acc_mask   = sb_byte_mask(sb.memop_type_i, off);
    assign size_mask  = sb_byte_mask(sb.memop_type_i, 2'b00);
    assign misaligned = sb_misaligned(sb.memop_type_i, off);
    assign store_data = sb.data_i << {off, 3'b000};
    assign full       = (count_q == (PtrW+1)'(NUM_ELEMS));
    assign empty      = (count_q == '0);
    assign pop        = !empty && sb.flush_chance_i;
    // A store hitting the head that leaves this cycle must not merge into a dying entry.
    assign head_hit   = pop && match_vec[head_q];

    always_comb begin
        for (int b = 0; b < SB_LANES; b++) begin
            size_bits[8*b +: 8] = {8{size_mask[b]}};
        end
    end

    segre_store_buffer_n_lookup #(
        .NUM_ELEMS (NUM_ELEMS)
    ) u_lookup (
        .entries_i     (entries_q),
        .waddr_i       (sb.addr_i[ADDR_SIZE-1:2]),
        .match_o       (match_vec),
        .match_idx_o   (match_idx),
        .match_entry_o (match_entry)
    );

    // Request decode and load forwarding.
    always_comb begin
        do_merge          = 1'b0;
        do_alloc          = 1'b0;
        sb.hit_o          = 1'b0;
        sb.miss_o         = 1'b0;
        sb.trouble_o      = 1'b0;
        sb.data_load_o    = '0;
        if (sb.req_store_i) begin
            if (misaligned) begin
                sb.trouble_o = 1'b1;
            end else if (match_entry.valid && !head_hit) begin
                do_merge = 1'b1;
            end else if (!full) begin
                do_alloc = 1'b1;
            end else begin
                sb.trouble_o = 1'b1;
            end
        end else if (sb.req_load_i) begin
            if (misaligned) begin
                sb.trouble_o = 1'b1;
            end else if (!match_entry.valid) begin
                sb.miss_o = 1'b1;
            end else if ((match_entry.mask & acc_mask) == acc_mask) begin
                sb.hit_o       = 1'b1;
                sb.data_load_o = (match_entry.data >> {off, 3'b000}) & size_bits;
            end else begin
                sb.trouble_o = 1'b1;
            end
        end
    end

    assign sb.buffer_merge_o = do_merge;

    // Next-state of the entry array and pointers.
    always_comb begin
        sb_entry_t e;
        entries_d = entries_q;
        e         = match_entry;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
        end
        if (do_merge) begin
            for (int b = 0; b < SB_LANES; b++) begin
                if (acc_mask[b]) e.data[8*b +: 8] = store_data[8*b +: 8];
            end
            e.mask               = e.mask | acc_mask;
            e.id                 = sb.instr_id_i;
            entries_d[match_idx] = e;
        end
        if (do_alloc) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].waddr = sb.addr_i[ADDR_SIZE-1:2];
            entries_d[tail_q].data  = store_data & {{8{acc_mask[3]}}, {8{acc_mask[2]}},
                                                    {8{acc_mask[1]}}, {8{acc_mask[0]}}};
            entries_d[tail_q].mask  = acc_mask;
            entries_d[tail_q].id    = sb.instr_id_i;
        end
        head_d  = head_q + PtrW'(pop);
        tail_d  = tail_q + PtrW'(do_alloc);
        count_d = count_q + (PtrW+1)'(do_alloc) - (PtrW+1)'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign sb.full_o        = full;
    assign sb.empty_o       = empty;
    assign sb.flush_valid_o = !empty;
    assign sb.addr_o        = empty ? '0 : {entries_q[head_q].waddr, 2'b00};
    assign sb.data_flush_o  = empty ? '0 : entries_q[head_q].data;
    assign sb.byte_en_o     = empty ? '0 : entries_q[head_q].mask;
    assign sb.flush_id_o    = empty ? '0 : entries_q[head_q].id;

endmodule

// File: tb/tb_segre_store_buffer_n.sv
// Directed bench for segre_store_buffer_n. The driver issues one vector per cycle and queues
// the hand-computed response; a monitor on the falling edge pops and compares.
module tb_segre_store_buffer_n;
    import segre_store_buffer_n_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic obs = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    segre_store_buffer_n_if sb_if ();

    segre_store_buffer_n #(
        .NUM_ELEMS (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb_if)
    );

    typedef struct {
        string       name;
        logic [109:0] v; // {hit,miss,trb,mrg,full,empty,fvalid,dload,faddr,fdata,fbe,fid}
    } exp_t;

    exp_t sb_q[$];

    always @(negedge clk) begin
        if (obs) begin
            exp_t e;
            logic [109:0] act;
            act = {sb_if.hit_o, sb_if.miss_o, sb_if.trouble_o, sb_if.buffer_merge_o,
                   sb_if.full_o, sb_if.empty_o, sb_if.flush_valid_o, sb_if.data_load_o,
                   sb_if.addr_o, sb_if.data_flush_o, sb_if.byte_en_o, sb_if.flush_id_o};
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got %h, required nothing queued", act);
            end else begin
                e = sb_q.pop_front();
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h required %h", e.name, act, e.v);
                end
            end
        end
    end

    task automatic step(input string name, input logic st, input logic ld,
                        input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                        input logic [2:0] id, input logic ch,
                        input logic hit, input logic miss, input logic trb, input logic mrg,
                        input logic full, input logic empty, input logic [31:0] dl,
                        input logic [31:0] fa, input logic [31:0] fd, input logic [3:0] be,
                        input logic [2:0] fid);
        exp_t e;
        sb_if.req_store_i    = st;
        sb_if.req_load_i     = ld;
        sb_if.addr_i         = a;
        sb_if.data_i         = d;
        sb_if.memop_type_i   = memop_data_type_e'(t);
        sb_if.instr_id_i     = id;
        sb_if.flush_chance_i = ch;
        e.name = name;
        e.v    = {hit, miss, trb, mrg, full, empty, !empty, dl, fa, fd, be, fid};
        sb_q.push_back(e);
        obs = 1'b1;
        @(posedge clk);
        #1;
        obs = 1'b0;
    endtask

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_if.req_store_i    = 1'b0;
        sb_if.req_load_i     = 1'b0;
        sb_if.addr_i         = '0;
        sb_if.data_i         = '0;
        sb_if.memop_type_i   = WORD;
        sb_if.instr_id_i     = '0;
        sb_if.flush_chance_i = 1'b0;
        @(posedge clk);
        #1;
        //   name          st ld addr   data        t id ch  hit ms tr mg fu em dload       faddr  fdata       be   fid
        step("in_reset",   0, 0, 0,     0,          W, 0, 0, 0, 0, 0, 0, 0, 1, 0,          0,     0,          0,   0);
        rst = 1'b0;
        step("after_rst",  0, 0, 0,     0,          W, 0, 0, 0, 0, 0, 0, 0, 1, 0,          0,     0,          0,   0);
        step("st_w100",    1, 0, 'h100, 'hDEADBEEF, W, 1, 0, 0, 0, 0, 0, 0, 1, 0,          0,     0,          0,   0);
        step("ld_w100",    0, 1, 'h100, 0,          W, 0, 0, 1, 0, 0, 0, 0, 0, 'hDEADBEEF, 'h100, 'hDEADBEEF, 'hF, 1);
        step("st_b101",    1, 0, 'h101, 'hAA,       B, 2, 0, 0, 0, 0, 1, 0, 0, 0,          'h100, 'hDEADBEEF, 'hF, 1);
        step("ld_merged",  0, 1, 'h100, 0,          W, 0, 0, 1, 0, 0, 0, 0, 0, 'hDEADAAEF, 'h100, 'hDEADAAEF, 'hF, 2);
        step("st_h202",    1, 0, 'h202, 'h1234,     H, 3, 0, 0, 0, 0, 0, 0, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("ld_partial", 0, 1, 'h200, 0,          W, 0, 0, 0, 0, 1, 0, 0, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("ld_h202",    0, 1, 'h202, 0,          H, 0, 0, 1, 0, 0, 0, 0, 0, 'h1234,     'h100, 'hDEADAAEF, 'hF, 2);
        step("ld_miss300", 0, 1, 'h300, 0,          B, 0, 0, 0, 1, 0, 0, 0, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("ld_misalgn", 0, 1, 'h201, 0,          H, 0, 0, 0, 0, 1, 0, 0, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("st_w300",    1, 0, 'h300, 'h11223344, W, 4, 0, 0, 0, 0, 0, 0, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("st_w400",    1, 0, 'h400, 'h55667788, W, 5, 0, 0, 0, 0, 0, 0, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("st_full",    1, 0, 'h500, 'h99,       W, 6, 0, 0, 0, 1, 0, 1, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("full_held",  0, 0, 0,     0,          W, 0, 0, 0, 0, 0, 0, 1, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("drain_100",  0, 0, 0,     0,          W, 0, 1, 0, 0, 0, 0, 1, 0, 0,          'h100, 'hDEADAAEF, 'hF, 2);
        step("retry_500",  1, 0, 'h500, 'h99,       W, 6, 0, 0, 0, 0, 0, 0, 0, 0,          'h200, 'h12340000, 'hC, 3);
        step("ld_w500",    0, 1, 'h500, 0,          W, 0, 0, 1, 0, 0, 0, 1, 0, 'h99,       'h200, 'h12340000, 'hC, 3);
        step("drain_200",  0, 0, 0,     0,          W, 0, 1, 0, 0, 0, 0, 1, 0, 0,          'h200, 'h12340000, 'hC, 3);
        step("st_headpop", 1, 0, 'h300, 'h55,       B, 7, 1, 0, 0, 0, 0, 0, 0, 0,          'h300, 'h11223344, 'hF, 4);
        step("ld_b300",    0, 1, 'h300, 0,          B, 0, 0, 1, 0, 0, 0, 0, 0, 'h55,       'h400, 'h55667788, 'hF, 5);
        rst = 1'b1;
        step("mid_reset",  0, 0, 0,     0,          W, 0, 0, 0, 0, 0, 0, 0, 1, 0,          0,     0,          0,   0);
        rst = 1'b0;
        step("post_reset", 0, 0, 0,     0,          W, 0, 0, 0, 0, 0, 0, 0, 1, 0,          0,     0,          0,   0);
        step("ld_gone400", 0, 1, 'h400, 0,          W, 0, 0, 0, 1, 0, 0, 0, 1, 0,          0,     0,          0,   0);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unchecked_entries: got %0d left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
